// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample default and
// divider / counter-width helpers used by uart_rx_unit and uart_baud_tick.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_state_e;

  localparam int OVERSAMPLE_DEF = 16;

  // Rounded clocks per oversample tick.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + baud * oversample / 2) / (baud * oversample);
  endfunction

  // Bits needed for a counter spanning 0..n-1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rx_unit_if.sv
// CPU-bus side of the UART receiver (byte, status and acknowledge).
// Defining UART_RX_PARITY_EN adds parity_odd and rx_parity_err.
interface uart_rx_unit_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_overrun;
  logic       rx_frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_odd;
  logic       rx_parity_err;

  modport slave  (output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy, rx_parity_err,
                  input  rx_ack, parity_odd);
  modport master (input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy, rx_parity_err,
                  output rx_ack, parity_odd);
`else
  modport slave  (output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
                  input  rx_ack);
  modport master (input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy,
                  output rx_ack);
`endif
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: one-cycle tick every DIV clocks, with a synchronous
// restart that re-phases the count (shared with the transmitter).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int DIV = 651
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = cnt_width(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = 1'b0;
    cnt_d = cnt_q + CNT_W'(1);
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      tick  = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_unit.sv
// 16x-oversampled 8N1 UART receiver holding one byte plus sticky status until acked.
// Build option UART_RX_PARITY_EN inserts a parity bit between data and stop.
module uart_rx_unit
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic           sys_clk,
  input  logic           reset,
  input  logic           UART_RX,
  uart_rx_unit_if.slave  bus
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SUB_W = cnt_width(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID = SUB_W'(OVERSAMPLE / 2 - 1);

  uart_state_e      state_q, state_d;
  logic             sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d, data_q, data_d;
  logic             valid_q, valid_d, overrun_q, overrun_d, frame_err_q, frame_err_d;
`ifdef UART_RX_PARITY_EN
  logic             parity_err_q, parity_err_d;
`endif
  logic             rx_s, fall, restart, tick, mid;

  assign rx_s    = sync2_q;
  assign fall    = rx_prev_q & ~rx_s;
  assign restart = (state_q == IDLE) && fall;
  assign mid     = tick && (sub_q == SUB_MID);

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .sys_clk (sys_clk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    sync1_d     = UART_RX;
    sync2_d     = sync1_q;
    rx_prev_d   = sync2_q;
    state_d     = state_q;
    sub_d       = sub_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
`ifdef UART_RX_PARITY_EN
    parity_err_d = parity_err_q;
`endif
    if (tick) sub_d = (sub_q == SUB_MAX) ? '0 : sub_q + SUB_W'(1);
    if (bus.rx_ack) begin
      valid_d     = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_d = 1'b0;
`endif
    end
    unique case (state_q)
      IDLE: begin
        sub_d     = '0;
        bit_idx_d = '0;
        if (fall) state_d = START;
      end
      START: if (mid) state_d = rx_s ? IDLE : DATA;
      DATA: if (mid) begin
        shift_d   = {rx_s, shift_q[7:1]};
        bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_idx_q == 3'd7) state_d = PARITY;
`else
        if (bit_idx_q == 3'd7) state_d = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (mid) begin
        if (rx_s != ((^shift_q) ^ bus.parity_odd)) parity_err_d = 1'b1;
        state_d = STOP;
      end
`endif
      STOP: if (mid) begin
        if (rx_s) begin
          // An ack landing on the commit cycle frees the holding register.
          if (!valid_q || bus.rx_ack) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = WAIT_IDLE;
        end
      end
      WAIT_IDLE: if (rx_s) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      sub_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      rx_prev_q   <= rx_prev_d;
      sub_q       <= sub_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign bus.rx_data      = data_q;
  assign bus.rx_valid     = valid_q;
  assign bus.rx_overrun   = overrun_q;
  assign bus.rx_frame_err = frame_err_q;
  assign bus.rx_busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign bus.rx_parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_unit.sv
// Self-checking bench for uart_rx_unit: table of frames checked through a
// scoreboard queue, plus hand-written glitch, reset, ack-timing sequences.
`timescale 1ns/1ps
module tb_uart_rx_unit;

  localparam int CLK_FREQ = 16_000_000;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;
  // (16e6 + 115200*8) / (115200*16) = 9.18 -> 9 clocks per tick
  localparam int DIV_EXP  = 9;
  localparam int BIT_CYC  = DIV_EXP * OS;
  // start edge -> 2 sync flops + edge flop, then 152 ticks to mid stop bit, +1 to register
  localparam int LAT_EXP  = 3 + 152 * DIV_EXP - 1 + 1;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  logic line    = 1'b1;

  uart_rx_unit_if bus_if();

  uart_rx_unit #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .OVERSAMPLE(OS)) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .UART_RX (line),
    .bus     (bus_if)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = -1;
  logic prev_valid = 1'b0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) begin
    if (bus_if.rx_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= bus_if.rx_valid;
  end

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       overrun;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    int         bc;
    bit         bad_stop;
    bit         ack_first;
    exp_t       e;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[8];

  function automatic vec_t mk(input logic [7:0] d, input int bc, input bit bad, input bit ack,
                              input logic [7:0] ed, input logic ev, input logic eo, input logic ef);
    vec_t v;
    v.d = d; v.bc = bc; v.bad_stop = bad; v.ack_first = ack;
    v.e.data = ed; v.e.valid = ev; v.e.overrun = eo; v.e.ferr = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int bc, input bit bad_stop);
    @(negedge sys_clk);
    start_cyc = cyc;
    line = 1'b0;
    repeat (bc) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      line = d[i];
      repeat (bc) @(negedge sys_clk);
    end
    if (bad_stop) begin
      line = 1'b0;
      repeat (2 * bc) @(negedge sys_clk);
    end
    line = 1'b1;
    repeat (bc) @(negedge sys_clk);
  endtask

  task automatic pulse_ack();
    @(negedge sys_clk);
    bus_if.rx_ack = 1'b1;
    @(negedge sys_clk);
    bus_if.rx_ack = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus_if.rx_busy && n < 4 * BIT_CYC) begin
      @(negedge sys_clk);
      n++;
    end
    chk({name, ".idle"}, bus_if.rx_busy, 0);
    repeat (2) @(negedge sys_clk);
  endtask

  task automatic sb_check(input string name);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, actual=0 required=1 entries", name);
      return;
    end
    e = sb_q.pop_front();
    chk({name, ".data"},    bus_if.rx_data,      e.data);
    chk({name, ".valid"},   bus_if.rx_valid,     e.valid);
    chk({name, ".overrun"}, bus_if.rx_overrun,   e.overrun);
    chk({name, ".ferr"},    bus_if.rx_frame_err, e.ferr);
  endtask

  task automatic expect_frame(input string name, input logic [7:0] d, input int bc, input bit bad,
                              input logic [7:0] ed, input logic ev, input logic eo, input logic ef);
    exp_t e;
    e.data = ed; e.valid = ev; e.overrun = eo; e.ferr = ef;
    sb_q.push_back(e);
    send_frame(d, bc, bad);
    wait_idle(name);
    sb_check(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bus_if.rx_ack = 1'b0;

    vecs[0] = mk(8'h08, BIT_CYC,              0, 0, 8'h08, 1, 0, 0);
    vecs[1] = mk(8'h10, BIT_CYC,              0, 0, 8'h08, 1, 1, 0);
    vecs[2] = mk(8'h10, BIT_CYC,              0, 1, 8'h10, 1, 0, 0);
    vecs[3] = mk(8'h55, BIT_CYC,              1, 1, 8'h10, 0, 0, 1);
    vecs[4] = mk(8'hA5, BIT_CYC,              0, 0, 8'hA5, 1, 0, 1);
    vecs[5] = mk(8'h96, BIT_CYC * 103 / 100,  0, 1, 8'h96, 1, 0, 0);
    vecs[6] = mk(8'hC3, BIT_CYC,              0, 1, 8'hC3, 1, 0, 0);
    vecs[7] = mk(8'h96, BIT_CYC * 97 / 100,   0, 1, 8'h96, 1, 0, 0);

    repeat (4) @(negedge sys_clk);
    chk("reset.data",    bus_if.rx_data,      0);
    chk("reset.valid",   bus_if.rx_valid,     0);
    chk("reset.overrun", bus_if.rx_overrun,   0);
    chk("reset.ferr",    bus_if.rx_frame_err, 0);
    chk("reset.busy",    bus_if.rx_busy,      0);
    reset = 1'b0;
    repeat (5) @(negedge sys_clk);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].ack_first) pulse_ack();
      rise_cyc = -1;
      sb_q.push_back(vecs[i].e);
      send_frame(vecs[i].d, vecs[i].bc, vecs[i].bad_stop);
      if (i == 0) begin
        lat = rise_cyc - start_cyc;
        checks++;
        if (lat < LAT_EXP - 2 || lat > LAT_EXP + 2) begin
          errors++;
          $display("FAIL latency: actual=%0d required=%0d cycles", lat, LAT_EXP);
        end
      end
      wait_idle($sformatf("vec%0d", i));
      sb_check($sformatf("vec%0d", i));
    end

    pulse_ack();
    chk("ack.valid",   bus_if.rx_valid,     0);
    chk("ack.overrun", bus_if.rx_overrun,   0);
    chk("ack.data",    bus_if.rx_data,      8'h96);

    // ack coinciding with the commit edge of a new byte
    expect_frame("pre_ack", 8'h11, BIT_CYC, 0, 8'h11, 1, 0, 0);
    fork
      send_frame(8'h22, BIT_CYC, 0);
      begin
        @(negedge sys_clk);
        repeat (LAT_EXP - 1) @(negedge sys_clk);
        bus_if.rx_ack = 1'b1;
        @(negedge sys_clk);
        bus_if.rx_ack = 1'b0;
      end
    join
    wait_idle("ack_commit");
    chk("ack_commit.data",    bus_if.rx_data,    8'h22);
    chk("ack_commit.valid",   bus_if.rx_valid,   1);
    chk("ack_commit.overrun", bus_if.rx_overrun, 0);

    // 3/16-bit glitch
    pulse_ack();
    @(negedge sys_clk);
    line = 1'b0;
    repeat (3 * DIV_EXP) @(negedge sys_clk);
    line = 1'b1;
    chk("glitch.busy_hi", bus_if.rx_busy, 1);
    repeat (BIT_CYC) @(negedge sys_clk);
    chk("glitch.busy_lo", bus_if.rx_busy,      0);
    chk("glitch.valid",   bus_if.rx_valid,     0);
    chk("glitch.ferr",    bus_if.rx_frame_err, 0);
    chk("glitch.overrun", bus_if.rx_overrun,   0);

    // reset in the middle of bit 4
    expect_frame("pre_rst", 8'h7E, BIT_CYC, 0, 8'h7E, 1, 0, 0);
    fork
      send_frame(8'hFF, BIT_CYC, 0);
      begin
        @(negedge sys_clk);
        repeat (5 * BIT_CYC + BIT_CYC / 2) @(negedge sys_clk);
        chk("rst_mid.busy_before", bus_if.rx_busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid.data",  bus_if.rx_data,  0);
        chk("rst_mid.valid", bus_if.rx_valid, 0);
        chk("rst_mid.busy",  bus_if.rx_busy,  0);
        repeat (3) @(negedge sys_clk);
        reset = 1'b0;
      end
    join
    expect_frame("post_rst", 8'h3C, BIT_CYC, 0, 8'h3C, 1, 0, 0);

    // ack with nothing held still clears a framing error
    pulse_ack();
    expect_frame("ferr2", 8'h55, BIT_CYC, 1, 8'h3C, 0, 0, 1);
    pulse_ack();
    chk("ack_idle.ferr",  bus_if.rx_frame_err, 0);
    chk("ack_idle.valid", bus_if.rx_valid,     0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_unit.md
Name: uart_rx_unit

Overview:
- UART receiver directly upstream of the CPU core; deserialises the board-level UART_RX line into bytes for the CPU's peripheral bus.
- 16x oversampling, 8N1 framing, LSB first.
- Holds one received byte plus sticky status until the CPU acknowledges it.
- Default rate is 9600 baud from a 100 MHz sys_clk, giving a bit period of about 104166 ns.

Parameters:
- CLK_FREQ, 100000000, sys_clk frequency in Hz.
- BAUD, 9600, line rate in bit/s.
- OVERSAMPLE, 16, sample ticks per bit; must be even and at least 8.

Ports:
- sys_clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset; clears all state.
- UART_RX  in  1  serial line, asynchronous to sys_clk; idles high.
- rx_data  out  8  last accepted byte.
- rx_valid  out  1  sticky; high while rx_data is unread.
- rx_ack  in  1  one-cycle pulse from the CPU bus; consumes the byte and clears status.
- rx_overrun  out  1  sticky; a byte was dropped while rx_valid was high.
- rx_frame_err  out  1  sticky; stop bit was sampled low.
- rx_busy  out  1  high in any state other than IDLE.

Behaviour:
- Interface: single clock domain, sys_clk. reset is asynchronous and active-high; it takes effect immediately, independent of the clock.
- Reset values: all outputs 0; FSM in IDLE; synchroniser flops preset to 1.
- Synchroniser: UART_RX passes through 2 flops to give rx_s. Edge detection uses rx_s and a third flop.
- Tick generator:
  - DIV = (CLK_FREQ + BAUD*OVERSAMPLE/2) / (BAUD*OVERSAMPLE), i.e. rounded; 651 at the defaults.
  - Counter wraps at DIV-1 and emits a one-cycle tick.
  - Counter is forced to 0 on the IDLE falling-edge detect so bit sampling is phase-aligned.
- Sub-counter: 0..OVERSAMPLE-1, advanced by tick. A bit is sampled when the sub-counter equals OVERSAMPLE/2-1 (mid-bit).
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: falling edge on rx_s goes to START; sub-counter and bit index are cleared.
  - START: at mid-bit, rx_s=0 goes to DATA; rx_s=1 is treated as a glitch and returns to IDLE with no flag set.
  - DATA: each mid-bit sample shifts into the shift register at bit[7] (right shift, LSB first). After the 8th sample, go to STOP.
  - STOP, sample rx_s=1: load the byte per the commit rules below, then go to IDLE.
  - STOP, sample rx_s=0: set rx_frame_err, do not load the byte, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s=1, then go to IDLE. A break condition therefore produces exactly one error.
- Commit (applies on a good stop bit):
  - rx_valid=0: rx_data takes the shift register and rx_valid is set.
  - rx_valid=1 with no rx_ack in the same cycle: rx_data keeps the old byte, the new byte is dropped, rx_overrun is set.
  - rx_ack in the same cycle as commit: the new byte loads, rx_valid stays 1, no overrun.
- Latency: rx_valid rises 1 sys_clk after the mid-stop-bit tick, about 9.5 bit times after the start edge.
- rx_ack clears rx_valid, rx_overrun and rx_frame_err on the next edge. rx_ack while rx_valid=0 is harmless and still clears the error flags.
- Reset mid-frame aborts the frame: outputs return to 0 and no partial byte is ever exposed.
- rx_busy = (state != IDLE).

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP and an extra input port parity_odd (1 bit).
  - At mid-bit in PARITY, the received bit is compared with the XOR of the data bits (inverted when parity_odd=1).
  - A mismatch sets sticky output rx_parity_err (cleared by rx_ack); the byte is still committed if the stop bit is good.
- Undefined: no PARITY state and no parity_odd or rx_parity_err ports; framing is 8N1 only.

Decomposition:
- Package uart_pkg:
  - state encoding constants: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE;
  - OVERSAMPLE default;
  - constant function for DIV and counter widths (clog2).
- Sub-module uart_baud_tick: divider counter with a sync restart input and a tick output. It is reused by the planned uart_tx_unit.

Test Plan:
- Byte 0x08: line idles high, frame sent at the nominal bit period -> rx_data=0x08, rx_valid=1, flags 0; rx_ack pulse -> rx_valid=0.
- Back-to-back 0x08 then 0x10 with no ack between -> rx_data stays 0x08, rx_overrun=1; after ack, send 0x10 again -> rx_data=0x10, rx_overrun=0.
- Glitch: line low for 3/16 of a bit -> stays in START, returns to IDLE, rx_busy drops, no flags, rx_valid stays 0.
- Framing: 0x55 with stop bit held low for 2 bits -> rx_frame_err=1, rx_valid=0; line returns high, then 0xA5 -> rx_data=0xA5, rx_valid=1.
- Reset mid-frame: assert reset at bit 4 of 0xFF -> all outputs 0 immediately; the next 0x3C frame is received correctly.
- Rate tolerance: bit period +/-3% (BAUD overridden to 115200 for speed) with 0x96 -> rx_data=0x96 with no errors.
